// File: rtl/piradip_sample_playlist_sequencer.sv
// Plays a table of sample-buffer segments (start/end/repeat) in order on each trigger.
// Optional macro PIRADIP_SEQ_GAP_EN adds a gap_cycles input and an idle GAP state between plays.
module piradip_sample_playlist_sequencer #(
    parameter int NUM_SEGMENTS = 8,
    parameter int OFFSET_WIDTH = 12,
    parameter int REPEAT_WIDTH = 8,
    localparam int IDX_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [OFFSET_WIDTH-1:0] cfg_start,
    input  logic [OFFSET_WIDTH-1:0] cfg_end,
    input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
    input  logic [IDX_W:0]          num_segments,
    input  logic                    loop_en,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic                    stream_stopped,
`ifdef PIRADIP_SEQ_GAP_EN
    input  logic [15:0]             gap_cycles,
`endif
    output logic                    stream_update,
    output logic                    stream_active,
    output logic                    stream_one_shot,
    output logic [OFFSET_WIDTH-1:0] stream_start_offset,
    output logic [OFFSET_WIDTH-1:0] stream_end_offset,
    output logic                    busy,
    output logic [IDX_W-1:0]        seg_idx,
    output logic                    done
);

    // state    | meaning
    // IDLE     | waiting for trigger
    // LOAD     | fetch table entry idx, reload repeat counter
    // ARM      | update strobe to buffer is high this cycle
    // WAIT_RUN | waiting for the buffer to leave stopped (enable lags the strobe)
    // RUN      | segment playing, waiting for stopped
    // NEXT     | choose repeat / next entry / loop / finish
    // GAP      | idle delay before the next play (gap build only)
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT_RUN,
        S_RUN,
        S_NEXT
`ifdef PIRADIP_SEQ_GAP_EN
        , S_GAP
`endif
    } state_e;

    localparam logic [IDX_W:0]        MAX_SEG = (IDX_W+1)'(NUM_SEGMENTS);
    localparam logic [IDX_W:0]        IDX_ONE = (IDX_W+1)'(1);
    localparam logic [REPEAT_WIDTH-1:0] REP_ONE = REPEAT_WIDTH'(1);

    logic [OFFSET_WIDTH-1:0] tbl_start_q [NUM_SEGMENTS];
    logic [OFFSET_WIDTH-1:0] tbl_end_q   [NUM_SEGMENTS];
    logic [REPEAT_WIDTH-1:0] tbl_rep_q   [NUM_SEGMENTS];

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [REPEAT_WIDTH-1:0] rep_q;
    logic                    upd_q;
    logic                    act_q;
    logic                    busy_q;
    logic                    done_q;
    logic [OFFSET_WIDTH-1:0] start_q;
    logic [OFFSET_WIDTH-1:0] end_q;
`ifdef PIRADIP_SEQ_GAP_EN
    logic [15:0]             gap_cnt_q;
    logic                    gap_load_q;
`endif

    logic [IDX_W:0] num_eff_d;
    logic [IDX_W:0] idx_inc_d;
    logic           more_d;
    logic           next_arm_d;
    logic           next_load_d;

    // Table is deliberately not reset; writes land in any state.
    always_ff @(posedge clk_in) begin
        if (cfg_we && ({1'b0, cfg_idx} < MAX_SEG)) begin
            tbl_start_q[cfg_idx] <= cfg_start;
            tbl_end_q[cfg_idx]   <= cfg_end;
            tbl_rep_q[cfg_idx]   <= cfg_repeat;
        end
    end

    always_comb begin
        num_eff_d   = (num_segments > MAX_SEG) ? MAX_SEG : num_segments;
        idx_inc_d   = {1'b0, idx_q} + IDX_ONE;
        more_d      = (idx_inc_d < num_eff_d);
        next_arm_d  = (rep_q != '0);
        next_load_d = !next_arm_d && (more_d || loop_en);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rep_q      <= '0;
            upd_q      <= 1'b0;
            act_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
`ifdef PIRADIP_SEQ_GAP_EN
            gap_cnt_q  <= '0;
            gap_load_q <= 1'b0;
`endif
        end else begin
            upd_q  <= 1'b0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                // Stop strobe: reload the buffer with active low, offsets unchanged.
                state_q <= S_IDLE;
                upd_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (trigger && !abort && (num_eff_d != '0)) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        start_q <= tbl_start_q[idx_q];
                        end_q   <= tbl_end_q[idx_q];
                        rep_q   <= tbl_rep_q[idx_q];
                        upd_q   <= 1'b1;
                        act_q   <= 1'b1;
                        state_q <= S_ARM;
                    end
                    S_ARM: begin
                        state_q <= S_WAIT_RUN;
                    end
                    S_WAIT_RUN: begin
                        if (!stream_stopped) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (stream_stopped) begin
                            state_q <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (next_arm_d) begin
                            rep_q <= rep_q - REP_ONE;
                        end else begin
                            idx_q <= more_d ? idx_inc_d[IDX_W-1:0] : '0;
                        end
                        if (!next_arm_d && !next_load_d) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
`ifdef PIRADIP_SEQ_GAP_EN
                        else if (gap_cycles != 16'd0) begin
                            state_q    <= S_GAP;
                            gap_cnt_q  <= gap_cycles - 16'd1;
                            gap_load_q <= next_load_d;
                        end
`endif
                        else if (next_load_d) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_ARM;
                            upd_q   <= 1'b1;
                            act_q   <= 1'b1;
                        end
                    end
`ifdef PIRADIP_SEQ_GAP_EN
                    S_GAP: begin
                        if (gap_cnt_q == 16'd0) begin
                            if (gap_load_q) begin
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_ARM;
                                upd_q   <= 1'b1;
                                act_q   <= 1'b1;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 16'd1;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stream_update       = upd_q;
    assign stream_active       = act_q;
    assign stream_one_shot     = busy_q;
    assign stream_start_offset = start_q;
    assign stream_end_offset   = end_q;
    assign busy                = busy_q;
    assign seg_idx             = idx_q;
    assign done                = done_q;

endmodule

// File: tb/tb_piradip_sample_playlist_sequencer.sv
// Bench for piradip_sample_playlist_sequencer: buffer model plus play-list reference.
// Build with PIRADIP_SEQ_GAP_EN to exercise the gap_cycles variant.
module tb_piradip_sample_playlist_sequencer;

    localparam int NSEG = 8;
    localparam int OW   = 12;
    localparam int RW   = 8;
    localparam int IW   = 3;
`ifdef PIRADIP_SEQ_GAP_EN
    localparam int GAP_T1 = 10;
`else
    localparam int GAP_T1 = 0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [OW-1:0] cfg_start = '0;
    logic [OW-1:0] cfg_end = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic [IW:0]   num_segments = '0;
    logic          loop_en = 1'b0;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic          stream_stopped = 1'b1;
`ifdef PIRADIP_SEQ_GAP_EN
    logic [15:0]   gap_cycles = '0;
`endif
    logic          stream_update, stream_active, stream_one_shot, busy, done;
    logic [OW-1:0] stream_start_offset, stream_end_offset;
    logic [IW-1:0] seg_idx;

    piradip_sample_playlist_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_end(cfg_end),
        .cfg_repeat(cfg_repeat), .num_segments(num_segments), .loop_en(loop_en),
        .trigger(trigger), .abort(abort), .stream_stopped(stream_stopped),
`ifdef PIRADIP_SEQ_GAP_EN
        .gap_cycles(gap_cycles),
`endif
        .stream_update(stream_update), .stream_active(stream_active),
        .stream_one_shot(stream_one_shot), .stream_start_offset(stream_start_offset),
        .stream_end_offset(stream_end_offset), .busy(busy), .seg_idx(seg_idx), .done(done)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference copy of the segment table
    int m_start [NSEG];
    int m_end   [NSEG];
    int m_rep   [NSEG];

    // Observation logs
    int upd_cyc[$];
    int upd_s[$];
    int upd_e[$];
    int upd_a[$];
    int upd_i[$];
    int stop_cyc[$];
    int done_cyc[$];
    int viol = 0;

    // Buffer model: goes running 1..3 cycles after the active strobe's next cycle,
    // plays end-start+1 words (one word when start > end), then reports stopped.
    bit            b_run = 1'b0;
    int            b_lo = 0;
    int            b_len = 0;
    logic [OW-1:0] prev_s = '0;
    logic [OW-1:0] prev_e = '0;
    bit            prev_rst = 1'b1;

    always @(negedge clk_in) begin
        #1;
        if (rst_in) begin
            b_run = 1'b0;
            stream_stopped = 1'b1;
        end else begin
            if (stream_update) begin
                upd_cyc.push_back(cyc);
                upd_s.push_back(int'(stream_start_offset));
                upd_e.push_back(int'(stream_end_offset));
                upd_a.push_back(int'(stream_active));
                upd_i.push_back(int'(seg_idx));
                if (stream_active) begin
                    b_run = 1'b1;
                    b_lo  = cyc + 1 + int'($urandom_range(1, 3));
                    b_len = (stream_start_offset <= stream_end_offset) ?
                            int'(stream_end_offset) - int'(stream_start_offset) + 1 : 1;
                end else begin
                    b_run = 1'b0;
                end
            end
            if (done) done_cyc.push_back(cyc);
            if (stream_one_shot !== busy) viol++;
            if (!stream_update && !prev_rst &&
                (stream_start_offset !== prev_s || stream_end_offset !== prev_e)) viol++;
            if (b_run && cyc >= b_lo + b_len) begin
                b_run = 1'b0;
                stop_cyc.push_back(cyc);
            end
            stream_stopped = !(b_run && cyc >= b_lo);
        end
        prev_s   = stream_start_offset;
        prev_e   = stream_end_offset;
        prev_rst = rst_in;
    end

    task automatic write_entry(input int i, input int s, input int e, input int r);
        @(negedge clk_in);
        cfg_we     = 1'b1;
        cfg_idx    = IW'(i);
        cfg_start  = OW'(s);
        cfg_end    = OW'(e);
        cfg_repeat = RW'(r);
        m_start[i] = s;
        m_end[i]   = e;
        m_rep[i]   = r;
        @(negedge clk_in);
        cfg_we = 1'b0;
    endtask

    task automatic prog_random();
        int s, e;
        for (int i = 0; i < NSEG; i++) begin
            s = int'($urandom_range(5, 4000));
            if ($urandom_range(0, 7) == 0) e = s - int'($urandom_range(1, 5));
            else e = s + int'($urandom_range(0, 5));
            write_entry(i, s, e, int'($urandom_range(0, 2)));
        end
    endtask

    function automatic int gap_rand();
`ifdef PIRADIP_SEQ_GAP_EN
        return int'($urandom_range(0, 3));
`else
        return 0;
`endif
    endfunction

    // One triggered sequence; in loop mode it stops after stop_after plays via abort.
    task automatic run_seq(input int num, input bit lp, input int stop_after,
                           input bit trig2, input int g);
        int es[$], ee[$], ei[$], en[$];
        int t0, n_eff, n_cmp, passes, n_before;
        upd_cyc.delete(); upd_s.delete(); upd_e.delete(); upd_a.delete(); upd_i.delete();
        stop_cyc.delete(); done_cyc.delete();
`ifdef PIRADIP_SEQ_GAP_EN
        gap_cycles = 16'(g);
`endif
        num_segments = (IW+1)'(num);
        loop_en = lp;
        @(negedge clk_in);
        trigger = 1'b1;
        t0 = cyc;
        for (int b = 0; b < 6000; b++) begin
            @(negedge clk_in);
            trigger = 1'b0;
            if (lp ? (upd_cyc.size() >= stop_after) : (done_cyc.size() != 0)) break;
            if (trig2 && cyc == t0 + 4) trigger = 1'b1;
            else if (busy && !done && $urandom_range(0, 7) == 0) trigger = 1'b1;
        end
        trigger = 1'b0;

        n_eff  = (num > NSEG) ? NSEG : num;
        passes = lp ? stop_after + 1 : 1;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < n_eff; i++)
                for (int r = 0; r <= m_rep[i]; r++) begin
                    es.push_back(m_start[i]); ee.push_back(m_end[i]);
                    ei.push_back(i); en.push_back(r == 0 ? 1 : 0);
                end

        if (lp) begin
            for (int b = 0; b < 500 && stream_stopped; b++) @(negedge clk_in);
            n_before = upd_cyc.size();
            abort = 1'b1;
            @(negedge clk_in);
            abort = 1'b0;
            check_eq("abort_update", int'(stream_update), 1);
            check_eq("abort_active", int'(stream_active), 0);
            check_eq("abort_busy", int'(busy), 0);
            repeat (6) @(negedge clk_in);
            check_eq("abort_no_done", done_cyc.size(), 0);
            check_eq("abort_one_strobe", upd_cyc.size(), n_before + 1);
            n_cmp = stop_after;
            check_eq("loop_reached", int'(upd_cyc.size() >= stop_after), 1);
        end else begin
            repeat (3) @(negedge clk_in);
            n_cmp = es.size();
            check_eq("n_updates", upd_cyc.size(), es.size());
        end

        for (int k = 0; k < n_cmp && k < upd_cyc.size(); k++) begin
            check_eq("upd_start", upd_s[k], es[k]);
            check_eq("upd_end", upd_e[k], ee[k]);
            check_eq("upd_active", upd_a[k], 1);
            check_eq("upd_seg_idx", upd_i[k], ei[k]);
            if (k == 0) check_eq("trig_latency", upd_cyc[0] - t0, 2);
            else if (k - 1 < stop_cyc.size())
                check_eq("stop_to_update", upd_cyc[k] - stop_cyc[k-1], (en[k] != 0 ? 3 : 2) + g);
            else check_eq("stop_seen", stop_cyc.size(), k);
        end

        if (!lp) begin
            check_eq("done_count", done_cyc.size(), 1);
            if (done_cyc.size() != 0 && stop_cyc.size() != 0)
                check_eq("done_latency", done_cyc[0] - stop_cyc[$], 2);
            check_eq("busy_after", int'(busy), 0);
        end
    endtask

    logic [31:0] out_vec;

    initial begin
        repeat (3) @(negedge clk_in);
        out_vec = {stream_update, stream_active, stream_one_shot, stream_start_offset,
                   stream_end_offset, busy, seg_idx, done};
        check_eq("reset_outputs", int'(out_vec), 0);
        rst_in = 1'b0;

        // Two entries, first repeated once; trigger again two cycles after the first strobe
        write_entry(0, 0, 99, 1);
        write_entry(1, 100, 199, 0);
        run_seq(2, 1'b0, 0, 1'b1, GAP_T1);

        // Empty table: trigger ignored
        upd_cyc.delete();
        num_segments = '0;
        @(negedge clk_in); trigger = 1'b1;
        @(negedge clk_in); trigger = 1'b0;
        repeat (8) @(negedge clk_in);
        check_eq("empty_no_update", upd_cyc.size(), 0);
        check_eq("empty_not_busy", int'(busy), 0);

        // Random tables and lengths, including a clamped segment count
        for (int t = 0; t < 5; t++) begin
            prog_random();
            run_seq(int'($urandom_range(1, NSEG)), 1'b0, 0, 1'b0, gap_rand());
        end
        run_seq(12, 1'b0, 0, 1'b0, gap_rand());

        // Single entry looping, aborted mid-play
        prog_random();
        run_seq(1, 1'b1, 4, 1'b0, gap_rand());
        run_seq(3, 1'b1, 6, 1'b0, gap_rand());

        // Reset while playing, then a clean restart from entry 0
        prog_random();
        num_segments = (IW+1)'(2);
        loop_en = 1'b0;
        @(negedge clk_in); trigger = 1'b1;
        @(negedge clk_in); trigger = 1'b0;
        for (int b = 0; b < 500 && stream_stopped; b++) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        out_vec = {stream_update, stream_active, stream_one_shot, stream_start_offset,
                   stream_end_offset, busy, seg_idx, done};
        check_eq("reset_in_run", int'(out_vec), 0);
        repeat (2) @(negedge clk_in);
        run_seq(2, 1'b0, 0, 1'b0, gap_rand());

        check_eq("hold_and_oneshot_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
